// File: rtl/rtmc_pkg.sv
// Shared types and helpers for the rtmc motor-command blocks.
// Holds the scheduler command record and the wrap-safe due test.
package rtmc_pkg;

    localparam int RTMC_SCHED_DEPTH = 4;
    localparam int RTMC_TW          = 16;

    typedef struct packed {
        logic [RTMC_TW-1:0] t;
        logic [7:0]         mc;
        logic [7:0]         oe;
    } sched_cmd_t;

    // Due when t - now, read as a signed value, is zero or negative.
    function automatic logic sched_due(input logic [RTMC_TW-1:0] t,
                                       input logic [RTMC_TW-1:0] now);
        logic [RTMC_TW-1:0] diff;
        diff = t - now;
        return (diff == '0) || diff[RTMC_TW-1];
    endfunction

endpackage

// File: rtl/rtmc_cmd_fifo.sv
// First-word fall-through FIFO of scheduler commands.
// Flush empties it synchronously; the head entry is always visible.
module rtmc_cmd_fifo
    import rtmc_pkg::*;
#(
    parameter int DEPTH = RTMC_SCHED_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  sched_cmd_t               din,
    input  logic                     pop,
    output sched_cmd_t               head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    sched_cmd_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    assign head  = mem[rd_ptr];
    assign level = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rtmc_step_sched.sv
// Time-triggered motor command scheduler: prescaled timebase plus
// a FIFO of commands applied to mc/mc_oe on the exact tick they are due.
module rtmc_step_sched
    import rtmc_pkg::*;
#(
    parameter int         DEPTH   = RTMC_SCHED_DEPTH,
    parameter int         TW      = RTMC_TW,
    parameter logic [7:0] SAFE_MC = 8'h00,
    parameter logic [7:0] SAFE_OE = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [7:0]               prescale,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [TW-1:0]            cmd_time,
    input  logic [7:0]               cmd_mc,
    input  logic [7:0]               cmd_oe,
    input  logic                     late_clr,
    output logic [TW-1:0]            now,
    output logic [7:0]               mc,
    output logic [7:0]               mc_oe,
    output logic                     fire,
    output logic                     late,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic [7:0]  cnt;
    logic        tick;
    logic        push;
    logic        pop;
    logic        due;
    logic [TW-1:0] diff;
    sched_cmd_t  din;
    sched_cmd_t  head;

    assign tick      = enable && (cnt >= prescale);
    assign cmd_ready = (level < LW'(DEPTH)) && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign din       = '{t: cmd_time, mc: cmd_mc, oe: cmd_oe};
    assign diff      = head.t - now;
    assign due       = (level != '0) && sched_due(head.t, now);
    assign pop       = enable && due && !flush;

    rtmc_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            now <= '0;
        end else if (enable) begin
            if (tick) begin
                cnt <= '0;
                now <= now + 1'b1;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc    <= SAFE_MC;
            mc_oe <= SAFE_OE;
            fire  <= 1'b0;
        end else if (flush) begin
            mc    <= SAFE_MC;
            mc_oe <= SAFE_OE;
            fire  <= 1'b0;
        end else if (pop) begin
            mc    <= head.mc;
            mc_oe <= head.oe;
            fire  <= 1'b1;
        end else begin
            fire  <= 1'b0;
        end
    end

    // A late fire wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            late <= 1'b0;
        else if (pop && (diff != '0))
            late <= 1'b1;
        else if (late_clr)
            late <= 1'b0;
    end

endmodule

// File: tb/tb_rtmc_step_sched.sv
// Scoreboard bench for rtmc_step_sched with a queue-based reference model.
module tb_rtmc_step_sched;

    logic        clk = 0;
    logic        rst = 1;
    logic        enable = 0;
    logic [7:0]  prescale = 0;
    logic        flush = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [15:0] cmd_time = 0;
    logic [7:0]  cmd_mc = 0;
    logic [7:0]  cmd_oe = 0;
    logic        late_clr = 0;
    logic [15:0] now;
    logic [7:0]  mc;
    logic [7:0]  mc_oe;
    logic        fire;
    logic        late;
    logic [2:0]  level;

    rtmc_step_sched dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .prescale  (prescale),
        .flush     (flush),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_time  (cmd_time),
        .cmd_mc    (cmd_mc),
        .cmd_oe    (cmd_oe),
        .late_clr  (late_clr),
        .now       (now),
        .mc        (mc),
        .mc_oe     (mc_oe),
        .fire      (fire),
        .late      (late),
        .level     (level)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int mc; int oe; } mcmd_t;
    typedef struct { int mc; int oe; } mexp_t;

    mcmd_t mq[$];
    mexp_t ex[$];
    int m_now, m_cnt, m_mc, m_oe, m_fire, m_late;
    int m_d;
    bit m_pop, m_push;
    int total = 0;
    int bad = 0;

    task automatic chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Reference model: the spec's rules in plain integer arithmetic.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            ex.delete();
            m_now = 0; m_cnt = 0; m_mc = 0; m_oe = 0; m_fire = 0; m_late = 0;
        end else begin
            m_push = cmd_valid && (mq.size() < 4) && !flush;
            m_pop = 0;
            m_d = 0;
            if (enable && !flush && mq.size() > 0) begin
                m_d = (mq[0].t - m_now + 65536) % 65536;
                m_pop = (m_d == 0) || (m_d >= 32768);
            end
            if (flush) begin
                mq.delete();
                m_mc = 0; m_oe = 0; m_fire = 0;
            end else if (m_pop) begin
                m_mc = mq[0].mc;
                m_oe = mq[0].oe;
                m_fire = 1;
                ex.push_back('{mq[0].mc, mq[0].oe});
                void'(mq.pop_front());
            end else begin
                m_fire = 0;
            end
            if (m_pop && m_d != 0) m_late = 1;
            else if (late_clr) m_late = 0;
            if (m_push)
                mq.push_back('{int'(cmd_time), int'(cmd_mc), int'(cmd_oe)});
            if (enable) begin
                if (m_cnt >= int'(prescale)) begin
                    m_cnt = 0;
                    m_now = (m_now + 1) % 65536;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    // Monitor: compares outputs and pops the scoreboard on each fire.
    always @(negedge clk) begin
        if (!rst) begin
            chk("now", int'(now), m_now);
            chk("level", int'(level), mq.size());
            chk("mc", int'(mc), m_mc);
            chk("mc_oe", int'(mc_oe), m_oe);
            chk("late", int'(late), m_late);
            chk("fire", int'(fire), m_fire);
            chk("cmd_ready", int'(cmd_ready), int'((mq.size() < 4) && !flush));
            if (fire) begin
                if (ex.size() == 0) begin
                    chk("fire_unexpected", 1, 0);
                end else begin
                    mexp_t e;
                    e = ex.pop_front();
                    chk("fire_mc", int'(mc), e.mc);
                    chk("fire_oe", int'(mc_oe), e.oe);
                end
            end else if (ex.size() != 0) begin
                chk("fire_missed", 0, ex.size());
                ex.delete();
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(int t, int m, int o);
        cmd_valid = 1;
        cmd_time = 16'(t);
        cmd_mc = 8'(m);
        cmd_oe = 8'(o);
        step(1);
        cmd_valid = 0;
    endtask

    initial begin
        int tv;
        step(3);
        rst = 0;
        chk("rst_level", int'(level), 0);
        chk("rst_now", int'(now), 0);
        chk("rst_mc", int'(mc), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        enable = 1;
        step(8);
        chk("idle_now", int'(now), 8);

        prescale = 3;
        push(m_now + 8, 8'hA5, 8'hFF);
        step(60);
        chk("sched_mc", int'(mc), 8'hA5);
        chk("sched_oe", int'(mc_oe), 8'hFF);
        chk("sched_late", int'(late), 0);

        enable = 0;
        prescale = 0;
        tv = (m_now + 65531) % 65536;
        push(tv, 8'h11, 8'h01);
        push(tv, 8'h22, 8'h02);
        push(tv, 8'h33, 8'h03);
        push(tv, 8'h44, 8'h04);
        chk("full_ready", int'(cmd_ready), 0);
        enable = 1;
        step(6);
        chk("past_mc", int'(mc), 8'h44);
        chk("past_late", int'(late), 1);
        late_clr = 1;
        step(1);
        late_clr = 0;
        chk("late_clr", int'(late), 0);

        for (int i = 0; i < 70000 && m_now != 16'hFFF0; i++) step(1);
        chk("wrap_reach", int'(now), 16'hFFF0);
        push(1, 8'h77, 8'h0F);
        step(25);
        chk("wrap_mc", int'(mc), 8'h77);
        chk("wrap_late", int'(late), 0);
        push((m_now + 16'h8001) % 65536, 8'h66, 8'h06);
        step(3);
        chk("half_mc", int'(mc), 8'h66);
        chk("half_late", int'(late), 1);
        late_clr = 1;
        step(1);
        late_clr = 0;

        enable = 0;
        push((m_now + 65535) % 65536, 8'h99, 8'h09);
        step(5);
        chk("frozen_mc", int'(mc), 8'h66);
        enable = 1;
        step(2);
        chk("resume_mc", int'(mc), 8'h99);
        push(m_now, 8'h3C, 8'h3C);
        step(2);
        chk("pre_flush_mc", int'(mc), 8'h3C);
        enable = 0;
        push(m_now, 8'h01, 8'h01);
        push(m_now, 8'h02, 8'h02);
        push(m_now, 8'h03, 8'h03);
        chk("pre_flush_level", int'(level), 3);
        flush = 1;
        step(1);
        flush = 0;
        chk("flush_level", int'(level), 0);
        chk("flush_mc", int'(mc), 0);
        chk("flush_oe", int'(mc_oe), 0);
        enable = 1;

        push(m_now, 8'h5A, 8'h5A);
        step(2);
        chk("pre_rst_mc", int'(mc), 8'h5A);
        push(m_now + 100, 8'hE1, 8'hE1);
        push(m_now + 100, 8'hE2, 8'hE2);
        @(negedge clk);
        #3;
        rst = 1;
        #1;
        chk("arst_mc", int'(mc), 0);
        chk("arst_oe", int'(mc_oe), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_now", int'(now), 0);
        step(2);
        rst = 0;
        push(m_now + 3, 8'hC3, 8'h3C);
        step(8);
        chk("post_rst_mc", int'(mc), 8'hC3);

        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            tv = (m_now + 65536 + $urandom_range(0, 60) - 20) % 65536;
            cmd_time = 16'(tv);
            cmd_mc = 8'($urandom);
            cmd_oe = 8'($urandom);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) prescale = 8'($urandom_range(0, 3));
            late_clr = ($urandom_range(0, 15) == 0);
            flush = ($urandom_range(0, 59) == 0);
            step(1);
        end
        cmd_valid = 0;
        late_clr = 0;
        flush = 0;
        enable = 1;
        step(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rtmc_step_sched.md
Name: rtmc_step_sched

Overview:
- Time-triggered command scheduler between the SPI command path and the motor output pins (mc / mc_oe).
- Software queues commands of the form {execute-at time, mc value, mc_oe value}. The block keeps a prescaled free-running timebase and applies each command to the motor pins on the exact tick it is due.
- Provides deterministic, jitter-free motor updates regardless of SPI latency.

Parameters:
- DEPTH, 4, command queue entries (power of two, >= 2).
- TW, 16, timebase and command time width in bits.
- SAFE_MC, 8'h00, mc value driven at reset and on flush.
- SAFE_OE, 8'h00, mc_oe value driven at reset and on flush.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  timebase runs and commands may fire while high.
- prescale  in  8  tick period minus 1, in clk cycles.
- flush  in  1  synchronous queue clear and safe outputs.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_time  in  TW  tick value at which the command executes.
- cmd_mc  in  8  mc value to apply.
- cmd_oe  in  8  mc_oe value to apply.
- late_clr  in  1  clears the sticky late flag.
- now  out  TW  current timebase value.
- mc  out  8  motor output register.
- mc_oe  out  8  motor output-enable register.
- fire  out  1  one-cycle pulse; mc/mc_oe were updated this edge.
- late  out  1  sticky; a command executed after its time.
- level  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high.
- Reset values: mc=SAFE_MC, mc_oe=SAFE_OE, now=0, prescaler count=0, queue empty (level=0), fire=0, late=0. cmd_ready returns to 1 on the first cycle after reset deasserts.
- Prescaler:
  - Counts clk cycles while enable=1.
  - tick asserts in the cycle where count >= prescale; count then returns to 0, otherwise increments.
  - prescale=0 gives a tick every cycle.
  - A prescale change mid-count takes effect immediately; the >= compare prevents overrun.
  - enable=0 freezes both count and now.
- Timebase: now increments by 1 on each tick and wraps at 2^TW-1 -> 0.
- Push:
  - cmd_ready = (level < DEPTH) && !flush.
  - An entry is written on the edge where cmd_valid && cmd_ready.
  - Queue order is strictly FIFO; there is no sorting by time.
  - Pushes are accepted while enable=0.
- Due test, wrap-safe: diff = head.time - now, mod 2^TW, interpreted as signed TW-bit.
  - Head is due when level != 0 and diff <= 0, i.e. diff==0 or diff[TW-1]==1.
  - Consequence: a time up to 2^(TW-1)-1 ticks ahead waits; anything else is treated as past.
- Fire, evaluated every cycle (not only on ticks):
  - If enable && head due && !flush, then on the next edge: mc<=head.mc, mc_oe<=head.oe, fire<=1, pop one entry.
  - At most one pop per cycle. Back-to-back due entries fire on consecutive cycles.
- Late: in the fire cycle, if diff != 0, late<=1. If late_clr and a late fire occur in the same cycle, set wins.
- Latency: an already-due command accepted on edge E fires on edge E+1. A future command fires on the edge after the cycle in which now == cmd_time.
- Simultaneous push and pop in one cycle are both performed; level is unchanged.
- Full queue: cmd_ready=0. There is no pop-through; a pop frees space on the following cycle.
- Flush (priority over fire and push):
  - On the next edge: queue empty, mc=SAFE_MC, mc_oe=SAFE_OE, fire=0.
  - now, prescaler and late are unaffected.
- fire is a registered pulse; it is 0 in every cycle where no pop occurred.
- Reset asserted mid-operation immediately forces all reset values, including outputs, asynchronously.

Decomposition:
- rtmc_pkg additions:
  - typedef sched_cmd_t {logic [TW-1:0] t; logic [7:0] mc; logic [7:0] oe;}
  - constants RTMC_SCHED_DEPTH=4, RTMC_TW=16.
  - function sched_due(t, now) returning the wrap-safe due bit.
- Sub-module rtmc_cmd_fifo:
  - Synchronous FIFO of sched_cmd_t with push/pop/flush/level.
  - Head entry visible combinationally (first-word fall-through).
- Top-level rtmc_step_sched holds the prescaler, timebase, due/fire logic, and the output and late registers.

Test Plan:
- Reset then idle, prescale=0, enable=1 -> mc=00, mc_oe=00, now increments every cycle, cmd_ready=1, level=0, fire never asserts.
- prescale=3. Push {t=10, mc=A5, oe=FF} at now=2 -> now advances every 4 cycles; single fire pulse on the edge after now==10; mc=A5, mc_oe=FF; late=0.
- Push 4 commands with t=now-5 (already past) -> cmd_ready=0 after the 4th; fires on 4 consecutive cycles in FIFO order; late=1. Then late_clr -> late=0.
- Wrap: let now reach FFFE, push t=0001 -> no fire at FFFE/FFFF, fire at now==0001, late=0. Push t=now+8000h -> treated as past, fires next cycle, late=1.
- enable=0 with due head queued -> no fire, now frozen; reassert enable -> fires next cycle. Flush while 3 entries are queued and mc=3C -> level=0, mc=SAFE_MC, mc_oe=SAFE_OE, now unchanged.
- Assert rst mid-queue with mc=5A -> outputs go to SAFE values asynchronously; level=0, now=0; normal push/fire resumes after release.
